// File: rtl/fpga_config_loader.sv
// Byte-serial configuration loader: syncs on 0xA5, fills per-tile shadow registers,
// verifies an XOR checksum and commits every tile's config in a single cycle.
module fpga_config_loader #(
  parameter int NUM_TILES = 4,
  parameter int WORD_W    = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic [NUM_TILES*WORD_W-1:0] config_out,
  output logic [NUM_TILES-1:0]        use_ff_out,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int TW = $clog2(NUM_TILES + 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_LOAD, S_CHECK} state_t;

  // Handshake: a byte moves on any cycle with byte_valid && byte_ready;
  // byte_ready depends only on the registered state, never on byte_valid.
  state_t            state, next_state;
  logic [TW-1:0]     tile_idx;
  logic [1:0]        byte_idx;
  logic [7:0]        xsum;
  logic [WORD_W-1:0] shadow_cfg [NUM_TILES];
  logic [NUM_TILES-1:0] shadow_ff;

  logic accept, last_byte, flag_bad, sum_ok;

  assign busy       = (state != S_IDLE);
  assign byte_ready = busy;
  assign accept     = byte_valid && byte_ready;
  assign last_byte  = (byte_idx == 2'd3) && (tile_idx == TW'(NUM_TILES - 1));
  assign flag_bad   = (byte_idx == 2'd3) && (byte_in[7:1] != 7'd0);
  assign sum_ok     = (byte_in == xsum);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_SYNC;
      S_SYNC:  if (accept && byte_in == HEADER) next_state = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          if (flag_bad)       next_state = S_IDLE;
          else if (last_byte) next_state = S_CHECK;
        end
      end
      S_CHECK: if (accept) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_idx   <= '0;
      byte_idx   <= '0;
      xsum       <= '0;
      shadow_ff  <= '0;
      config_out <= '0;
      use_ff_out <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      for (int t = 0; t < NUM_TILES; t++) shadow_cfg[t] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) error <= 1'b0;
        S_SYNC: begin
          if (accept && byte_in == HEADER) begin
            tile_idx <= '0;
            byte_idx <= '0;
            xsum     <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            xsum <= xsum ^ byte_in;
            for (int t = 0; t < NUM_TILES; t++) begin
              if (tile_idx == TW'(t)) begin
                case (byte_idx)
                  2'd0:    shadow_cfg[t][23:16] <= byte_in;
                  2'd1:    shadow_cfg[t][15:8]  <= byte_in;
                  2'd2:    shadow_cfg[t][7:0]   <= byte_in;
                  default: shadow_ff[t]         <= byte_in[0];
                endcase
              end
            end
            if (byte_idx == 2'd3) begin
              byte_idx <= '0;
              tile_idx <= tile_idx + TW'(1);
              if (flag_bad) error <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (sum_ok) begin
              // Atomic commit: all tiles switch on the same edge.
              for (int t = 0; t < NUM_TILES; t++)
                config_out[t*WORD_W +: WORD_W] <= shadow_cfg[t];
              use_ff_out <= shadow_ff;
              done       <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
